down_counter_4: RTL

Programmable 4-bit down counter and divider for the synchronous-sequential counter set, complementary to the up-counting `counter_4` divide-by-two chain. It counts down from a loaded reload value and reloads automatically on reaching zero. It flags terminal count and drives a 50%-duty divided clock-enable output. The count bits are exposed individually as `out0`..`out3`, matching the existing counter outputs, so the same benches and waveform setups can be reused.

---
 rtl/counter_pkg.sv | 7 +
 rtl/down_counter_4_toggle_ff.sv | 14 +
 rtl/down_counter_4.sv | 57 +++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared constants and types for the synchronous counter set.
package counter_pkg;
   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_RST = 4'b1111;

   typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/down_counter_4_toggle_ff.sv
// T flip-flop with synchronous active-high reset to 0.
module toggle_ff (
   input  logic clk,
   input  logic rst,
   input  logic t,
   output logic q
);
   always_ff @(posedge clk) begin
      if (rst)
         q <= 1'b0;
      else if (t)
         q <= ~q;
   end
endmodule

// File: rtl/down_counter_4.sv
// Programmable 4-bit down counter / divider: reloads from rld at zero,
// flags terminal count and toggles a 50% divided output on every reload.
module down_counter_4
   import counter_pkg::*;
#(
   parameter int               WIDTH   = CNT_W,
   parameter logic [WIDTH-1:0] RST_VAL = CNT_RST
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic             out0,
   output logic             out1,
   output logic             out2,
   output logic             out3,
   output logic             tc,
   output logic             div_out
);
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] rld;
   logic             zero;
   logic             reload;

   assign zero   = (count == '0);
   // load wins over en, so a zero count under load must not reload/toggle
   assign reload = zero && en && !load;
   assign tc     = reload && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= RST_VAL;
         rld   <= RST_VAL;
      end else if (load) begin
         count <= din;
         rld   <= din;
      end else if (en) begin
         if (zero)
            count <= rld;
         else
            count <= count - 1'b1;
      end
   end

   toggle_ff u_div (
      .clk (clk),
      .rst (rst),
      .t   (reload),
      .q   (div_out)
   );

   assign out0 = count[0];
   assign out1 = count[1];
   assign out2 = count[2];
   assign out3 = count[3];
endmodule
